// File: rtl/note_recorder_if.sv
// Bus between the keyboard/sequencer side (master) and the song recorder (slave).
interface note_recorder_if #(
    parameter int DEPTH  = 64,
    parameter int NOTE_W = 5
);
    localparam int AW = $clog2(DEPTH);

    logic              en;
    logic [NOTE_W-1:0] note_in;
    logic              rec_btn;
    logic              stop_btn;
    logic              clear_btn;
    logic [AW-1:0]     rd_addr;
    logic [NOTE_W-1:0] rd_data;
    logic [AW:0]       length;
    logic [1:0]        state;
    logic              full;
    logic              beat;

    modport master (
        output en, note_in, rec_btn, stop_btn, clear_btn, rd_addr,
        input  rd_data, length, state, full, beat
    );

    modport slave (
        input  en, note_in, rec_btn, stop_btn, clear_btn, rd_addr,
        output rd_data, length, state, full, beat
    );
endinterface

// File: rtl/note_recorder.sv
// Records one keyboard note per beat into a song buffer readable by beat index.
// Optional NOTE_RECORDER_TRIM_EN: drop trailing rests from the recorded length on stop.
module note_recorder #(
    parameter int DEPTH    = 64,
    parameter int NOTE_W   = 5,
    parameter int BEAT_DIV = 25_000_000
) (
    input logic           clk,
    input logic           rst,
    note_recorder_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = (BEAT_DIV > 1) ? $clog2(BEAT_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(BEAT_DIV - 1);
    localparam logic [AW:0]   LEN_FULL = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_ARMED = 2'b01,
        S_REC   = 2'b10
    } state_e;

    state_e            state_q, state_d;
    logic [AW:0]       len_q, len_d;
    logic              full_q, full_d;
    logic              beat_q, beat_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [NOTE_W-1:0] rd_data_q;
    logic [AW:0]       len_inc;

    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [NOTE_W-1:0] wr_data;

    logic [NOTE_W-1:0] mem [DEPTH];

`ifdef NOTE_RECORDER_TRIM_EN
    // Length the song would have if it ended right after its last non-rest beat.
    logic [AW:0]       last_q, last_d;
`endif

    assign len_inc = len_q + 1'b1;

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        full_d  = full_q;
        cnt_d   = cnt_q;
        beat_d  = 1'b0;
        wr_en   = 1'b0;
        wr_addr = len_q[AW-1:0];
        wr_data = bus.note_in;
`ifdef NOTE_RECORDER_TRIM_EN
        last_d  = last_q;
`endif
        if (bus.en) begin
            case (state_q)
                S_IDLE: begin
                    cnt_d = '0;
                    if (bus.rec_btn) begin
                        state_d = S_ARMED;
                        len_d   = '0;
                        full_d  = 1'b0;
                    end else if (bus.clear_btn) begin
                        len_d  = '0;
                        full_d = 1'b0;
                    end
                end
                S_ARMED: begin
                    cnt_d = '0;
                    if (bus.stop_btn) begin
                        state_d = S_IDLE;
                        len_d   = '0;
                    end else if (bus.note_in != '0) begin
                        wr_en   = 1'b1;
                        wr_addr = '0;
                        len_d   = (AW + 1)'(1);
                        state_d = S_REC;
`ifdef NOTE_RECORDER_TRIM_EN
                        last_d  = (AW + 1)'(1);
`endif
                    end
                end
                S_REC: begin
                    if (bus.stop_btn) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
`ifdef NOTE_RECORDER_TRIM_EN
                        len_d   = last_q;
`endif
                    end else if (cnt_q == CNT_LAST) begin
                        cnt_d  = '0;
                        wr_en  = 1'b1;
                        beat_d = 1'b1;
                        len_d  = len_inc;
`ifdef NOTE_RECORDER_TRIM_EN
                        if (bus.note_in != '0) begin
                            last_d = len_inc;
                        end
`endif
                        if (len_inc == LEN_FULL) begin
                            full_d  = 1'b1;
                            state_d = S_IDLE;
`ifdef NOTE_RECORDER_TRIM_EN
                            len_d   = last_d;
`endif
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            full_q  <= 1'b0;
            beat_q  <= 1'b0;
            cnt_q   <= '0;
`ifdef NOTE_RECORDER_TRIM_EN
            last_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            full_q  <= full_d;
            beat_q  <= beat_d;
            cnt_q   <= cnt_d;
`ifdef NOTE_RECORDER_TRIM_EN
            last_q  <= last_d;
`endif
        end
    end

    // Song storage is not cleared on reset; the length mask hides stale entries.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= '0;
        end else if ({1'b0, bus.rd_addr} < len_q) begin
            rd_data_q <= mem[bus.rd_addr];
        end else begin
            rd_data_q <= '0;
        end
    end

    assign bus.rd_data = rd_data_q;
    assign bus.length  = len_q;
    assign bus.state   = state_q;
    assign bus.full    = full_q;
    assign bus.beat    = beat_q;
endmodule
